jvs_frame_rx: RTL and testbench

JVS_FRAME_RX -- requirements
Module: jvs_frame_rx

---
 rtl/jvs_defs_pkg.sv | 16 +
 rtl/jvs_rx_unescape.sv | 41 ++++
 rtl/jvs_frame_rx.sv | 129 ++++++++++++
 tb/tb_jvs_frame_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/jvs_defs_pkg.sv
// Shared JVS framing constants and the receive-FSM state type.
package jvs_defs_pkg;

  localparam logic [7:0] JVS_SYNC_BYTE      = 8'hE0;
  localparam logic [7:0] JVS_ESCAPE_BYTE    = 8'hD0;
  localparam logic [7:0] JVS_BROADCAST_ADDR = 8'hFF;

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_ADDR = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_SUM  = 3'd4
  } jvs_rx_state_t;

endpackage

// File: rtl/jvs_rx_unescape.sv
// Strips JVS escape sequences and flags sync bytes; registered, one cycle latency.
module jvs_rx_unescape
  import jvs_defs_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] raw_data,
  input  logic       raw_valid,
  output logic [7:0] unesc_data,
  output logic       unesc_valid,
  output logic       unesc_sync
);

  logic esc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      esc_q       <= 1'b0;
      unesc_data  <= 8'h00;
      unesc_valid <= 1'b0;
      unesc_sync  <= 1'b0;
    end else begin
      unesc_valid <= 1'b0;
      unesc_sync  <= 1'b0;
      if (raw_valid) begin
        if (raw_data == JVS_SYNC_BYTE) begin
          unesc_sync <= 1'b1;
          esc_q      <= 1'b0;
        end else if (!esc_q && raw_data == JVS_ESCAPE_BYTE) begin
          esc_q <= 1'b1;
        end else begin
          // an escaped byte (including a second D0) is sent as value-1
          unesc_data  <= esc_q ? raw_data + 8'd1 : raw_data;
          unesc_valid <= 1'b1;
          esc_q       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/jvs_frame_rx.sv
// JVS frame receiver: sync hunt, unescape, header/payload parse, checksum check.
// Optional address filtering is compiled in with JVS_RX_ADDR_FILTER_EN.
//
// state  | meaning
// S_HUNT | discard bytes until a sync byte
// S_ADDR | expecting the address field
// S_LEN  | expecting the length field
// S_DATA | receiving payload bytes
// S_SUM  | expecting the checksum byte
module jvs_frame_rx
  import jvs_defs_pkg::*;
#(
  parameter logic [7:0] MAXLEN = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [7:0] my_addr,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_first,
  output logic       out_last,
  output logic [7:0] frame_addr,
  output logic [7:0] frame_len,
  output logic       frame_done,
  output logic       frame_ok,
  output logic       err_sum,
  output logic       err_len,
  output logic       err_sync
);

  jvs_rx_state_t state;
  logic [7:0]    sum_q;
  logic [7:0]    remaining_q;
  logic          first_q;
  logic          drop;
  logic [7:0]    u_data;
  logic          u_valid;
  logic          u_sync;
  logic          live;
  logic          len_bad;
  logic          chk_match;
  logic          last_byte;

  jvs_rx_unescape u_unescape (
    .clk         (clk),
    .rst         (rst),
    .raw_data    (rx_data),
    .raw_valid   (rx_valid),
    .unesc_data  (u_data),
    .unesc_valid (u_valid),
    .unesc_sync  (u_sync)
  );

  // Outputs decode the registered unescaper directly so the total latency stays one cycle.
  assign live       = !rst && u_valid;
  assign len_bad    = (u_data == 8'd0) || ({1'b0, u_data} > {1'b0, MAXLEN});
  assign chk_match  = (u_data == sum_q);
  assign last_byte  = (remaining_q == 8'd1);

  assign out_valid  = live && (state == S_DATA) && !drop;
  assign out_data   = out_valid ? u_data : 8'h00;
  assign out_first  = out_valid && first_q;
  assign out_last   = out_valid && last_byte;
  assign frame_done = live && (state == S_SUM) && !drop;
  assign frame_ok   = frame_done && chk_match;
  assign err_sum    = frame_done && !chk_match;
  assign err_len    = live && (state == S_LEN) && len_bad;
  assign err_sync   = !rst && u_sync && (state != S_HUNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HUNT;
      sum_q       <= 8'h00;
      remaining_q <= 8'h00;
      first_q     <= 1'b0;
      frame_addr  <= 8'h00;
      frame_len   <= 8'h00;
    end else if (u_sync) begin
      state <= S_ADDR;
    end else if (u_valid) begin
      case (state)
        S_ADDR: begin
          frame_addr <= u_data;
          sum_q      <= u_data;
          state      <= S_LEN;
        end
        S_LEN: begin
          frame_len <= u_data;
          sum_q     <= sum_q + u_data;
          if (len_bad) begin
            state <= S_HUNT;
          end else if (u_data == 8'd1) begin
            state <= S_SUM;
          end else begin
            remaining_q <= u_data - 8'd1;
            first_q     <= 1'b1;
            state       <= S_DATA;
          end
        end
        S_DATA: begin
          sum_q       <= sum_q + u_data;
          remaining_q <= remaining_q - 8'd1;
          first_q     <= 1'b0;
          if (last_byte) state <= S_SUM;
        end
        S_SUM:   state <= S_HUNT;
        default: state <= S_HUNT;
      endcase
    end
  end

`ifdef JVS_RX_ADDR_FILTER_EN
  // Foreign frames are still parsed so sync/length errors keep being reported.
  always_ff @(posedge clk) begin
    if (rst || u_sync) begin
      drop <= 1'b0;
    end else if (u_valid && state == S_ADDR) begin
      drop <= !(u_data == my_addr || u_data == JVS_BROADCAST_ADDR);
    end
  end
`else
  logic unused_my_addr;
  assign unused_my_addr = ^my_addr;
  assign drop           = 1'b0;
`endif

endmodule

// File: tb/tb_jvs_frame_rx.sv
// Directed, table-driven bench for jvs_frame_rx with hand-written latency and reset sequences.
module tb_jvs_frame_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] my_addr;
  logic [7:0] out_data;
  logic       out_valid, out_first, out_last;
  logic [7:0] frame_addr, frame_len;
  logic       frame_done, frame_ok, err_sum, err_len, err_sync;

  always #5 clk = ~clk;

  jvs_frame_rx dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .my_addr    (my_addr),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_first  (out_first),
    .out_last   (out_last),
    .frame_addr (frame_addr),
    .frame_len  (frame_len),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .err_sum    (err_sum),
    .err_len    (err_len),
    .err_sync   (err_sync)
  );

  typedef struct packed {
    logic [7:0]        ma;
    int                nb;
    logic [0:9][7:0]   raw;
    int                no;
    logic [0:3][7:0]   outb;
    logic [0:3]        f;
    logic [0:3]        l;
    int                done;
    int                ok;
    int                esum;
    int                elen;
    int                esync;
    logic [7:0]        fa;
    logic [7:0]        fl;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] ma, input int nb, input logic [0:9][7:0] raw,
                              input int no, input logic [0:3][7:0] outb, input logic [0:3] f,
                              input logic [0:3] l, input int done, input int ok, input int esum,
                              input int elen, input int esync, input logic [7:0] fa,
                              input logic [7:0] fl);
    vec_t v;
    v.ma = ma; v.nb = nb; v.raw = raw; v.no = no; v.outb = outb; v.f = f; v.l = l;
    v.done = done; v.ok = ok; v.esum = esum; v.elen = elen; v.esync = esync;
    v.fa = fa; v.fl = fl;
    return v;
  endfunction

  // Monitor: collects emitted bytes and pulse counts; flags pulses with no byte behind them.
  logic [7:0] oq[$];
  bit         fq[$];
  bit         lq[$];
  int n_done = 0, n_ok = 0, n_esum = 0, n_elen = 0, n_esync = 0, lat_errs = 0;
  logic rxv_q = 1'b0;

  always @(posedge clk) rxv_q <= rx_valid;

  always @(negedge clk) begin
    if (out_valid) begin
      oq.push_back(out_data);
      fq.push_back(out_first);
      lq.push_back(out_last);
    end
    if (frame_done) n_done++;
    if (frame_done && frame_ok) n_ok++;
    if (err_sum) n_esum++;
    if (err_len) n_elen++;
    if (err_sync) n_esync++;
    if ((out_valid || frame_done || err_sum || err_len || err_sync) && !rxv_q) begin
      lat_errs++;
      $display("FAIL pulse_timing: output pulse at %0t without a byte one cycle earlier", $time);
    end
  end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t vecs[12];

  initial begin
    int b_q, b_done, b_ok, b_esum, b_elen, b_esync;

    vecs[0]  = mk(8'h01, 6, {8'hE0,8'h01,8'h03,8'h10,8'h11,8'h25,32'h0}, 2,
                  {8'h10,8'h11,16'h0}, 4'b1000, 4'b0100, 1, 1, 0, 0, 0, 8'h01, 8'h03);
    vecs[1]  = mk(8'h00, 6, {8'hE0,8'h00,8'h02,8'hD0,8'hDF,8'hE2,32'h0}, 1,
                  {8'hE0,24'h0}, 4'b1000, 4'b1000, 1, 1, 0, 0, 0, 8'h00, 8'h02);
    vecs[2]  = mk(8'h00, 6, {8'hE0,8'h00,8'h02,8'hD0,8'hCF,8'hD2,32'h0}, 1,
                  {8'hD0,24'h0}, 4'b1000, 4'b1000, 1, 1, 0, 0, 0, 8'h00, 8'h02);
    vecs[3]  = mk(8'h01, 6, {8'hE0,8'h01,8'h03,8'h10,8'h11,8'h26,32'h0}, 2,
                  {8'h10,8'h11,16'h0}, 4'b1000, 4'b0100, 1, 0, 1, 0, 0, 8'h01, 8'h03);
    vecs[4]  = mk(8'h01, 9, {8'hE0,8'h01,8'h05,8'h10,8'hE0,8'h01,8'h02,8'h20,8'h23,8'h0}, 2,
                  {8'h10,8'h20,16'h0}, 4'b1100, 4'b0100, 1, 1, 0, 0, 1, 8'h01, 8'h02);
    vecs[5]  = mk(8'h01, 3, {8'hE0,8'h01,8'h00,56'h0}, 0,
                  32'h0, 4'b0000, 4'b0000, 0, 0, 0, 1, 0, 8'h01, 8'h00);
    vecs[6]  = mk(8'h05, 4, {8'hE0,8'h05,8'h01,8'h06,48'h0}, 0,
                  32'h0, 4'b0000, 4'b0000, 1, 1, 0, 0, 0, 8'h05, 8'h01);
    vecs[7]  = mk(8'h03, 9, {8'hA5,8'hD0,8'hE0,8'h03,8'h04,8'h01,8'h02,8'h03,8'h0D,8'h0}, 3,
                  {8'h01,8'h02,8'h03,8'h0}, 4'b1000, 4'b0010, 1, 1, 0, 0, 0, 8'h03, 8'h04);
    vecs[8]  = mk(8'h02, 5, {8'hE0,8'hFF,8'h02,8'hF0,8'hF1,40'h0}, 1,
                  {8'hF0,24'h0}, 4'b1000, 4'b1000, 1, 1, 0, 0, 0, 8'hFF, 8'h02);
`ifdef JVS_RX_ADDR_FILTER_EN
    vecs[9]  = mk(8'h02, 5, {8'hE0,8'h01,8'h02,8'h33,8'h36,40'h0}, 0,
                  32'h0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 8'h01, 8'h02);
`else
    vecs[9]  = mk(8'h02, 5, {8'hE0,8'h01,8'h02,8'h33,8'h36,40'h0}, 1,
                  {8'h33,24'h0}, 4'b1000, 4'b1000, 1, 1, 0, 0, 0, 8'h01, 8'h02);
`endif
    vecs[10] = mk(8'h02, 8, {8'hE0,8'h02,8'h03,8'hD0,8'hCF,8'hD0,8'hD0,8'hA6,16'h0}, 2,
                  {8'hD0,8'hD1,16'h0}, 4'b1000, 4'b0100, 1, 1, 0, 0, 0, 8'h02, 8'h03);
    vecs[11] = mk(8'h02, 7, {8'hE0,8'h02,8'h02,8'hD0,8'hDF,8'hD0,8'hE3,24'h0}, 1,
                  {8'hE0,24'h0}, 4'b1000, 4'b1000, 1, 1, 0, 0, 0, 8'h02, 8'h02);

    // reset state
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; my_addr = 8'h01;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pulses", {out_valid, out_first, out_last, frame_done, frame_ok,
                           err_sum, err_len, err_sync}, 32'h0);
    check("reset_out_data", out_data, 8'h00);
    check("reset_frame_addr", frame_addr, 8'h00);
    check("reset_frame_len", frame_len, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // one-cycle latency, with an idle cycle inside the payload
    send(8'hE0); send(8'h01); send(8'h03); send(8'h10);
    @(negedge clk);
    check("lat_first_valid", out_valid, 1'b1);
    check("lat_first_data", out_data, 8'h10);
    check("lat_first_flag", out_first, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("lat_gap_no_valid", out_valid, 1'b0);
    send(8'h11);
    @(negedge clk);
    check("lat_last_data", out_data, 8'h11);
    check("lat_last_flag", {out_valid, out_first, out_last}, 3'b101);
    send(8'h25);
    @(negedge clk);
    check("lat_done", {frame_done, frame_ok, err_sum}, 3'b110);
    idle(3);

    for (int i = 0; i < 12; i++) begin
      my_addr = vecs[i].ma;
      b_q = oq.size(); b_done = n_done; b_ok = n_ok;
      b_esum = n_esum; b_elen = n_elen; b_esync = n_esync;
      for (int k = 0; k < vecs[i].nb; k++) send(vecs[i].raw[k]);
      idle(3);
      check($sformatf("v%0d_out_count", i), oq.size() - b_q, vecs[i].no);
      if (oq.size() - b_q == vecs[i].no) begin
        for (int j = 0; j < vecs[i].no; j++) begin
          check($sformatf("v%0d_out_data%0d", i, j), oq[b_q+j], vecs[i].outb[j]);
          check($sformatf("v%0d_out_first%0d", i, j), fq[b_q+j], vecs[i].f[j]);
          check($sformatf("v%0d_out_last%0d", i, j), lq[b_q+j], vecs[i].l[j]);
        end
      end
      check($sformatf("v%0d_done", i), n_done - b_done, vecs[i].done);
      check($sformatf("v%0d_ok", i), n_ok - b_ok, vecs[i].ok);
      check($sformatf("v%0d_err_sum", i), n_esum - b_esum, vecs[i].esum);
      check($sformatf("v%0d_err_len", i), n_elen - b_elen, vecs[i].elen);
      check($sformatf("v%0d_err_sync", i), n_esync - b_esync, vecs[i].esync);
      check($sformatf("v%0d_frame_addr", i), frame_addr, vecs[i].fa);
      check($sformatf("v%0d_frame_len", i), frame_len, vecs[i].fl);
    end

    // reset in the middle of a frame, checksum byte arriving with rst
    my_addr = 8'h01;
    b_q = oq.size(); b_done = n_done; b_ok = n_ok;
    b_esum = n_esum; b_elen = n_elen; b_esync = n_esync;
    send(8'hE0); send(8'h01); send(8'h03); send(8'h10); send(8'h11);
    rst = 1'b1; rx_data = 8'h25; rx_valid = 1'b1;
    @(negedge clk);
    check("rst_gates_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; rx_valid = 1'b0;
    idle(2);
    check("rst_frame_addr", frame_addr, 8'h00);
    check("rst_frame_len", frame_len, 8'h00);
    check("rst_out_count", oq.size() - b_q, 1);
    check("rst_no_done", n_done - b_done, 0);
    check("rst_no_errors", (n_esum - b_esum) + (n_elen - b_elen) + (n_esync - b_esync), 0);
    send(8'h01); send(8'h03); send(8'h10); send(8'h11); send(8'h25);
    idle(3);
    check("hunt_after_rst_out", oq.size() - b_q, 1);
    check("hunt_after_rst_done", n_done - b_done, 0);
    send(8'hE0); send(8'h01); send(8'h01); send(8'h02);
    idle(3);
    check("post_rst_len1_done", n_done - b_done, 1);
    check("post_rst_len1_ok", n_ok - b_ok, 1);
    check("post_rst_len1_no_out", oq.size() - b_q, 1);

    check("pulse_timing", lat_errs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
